mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory stage of the pipeline. Consumes the execute-stage request and drives data memory
//  over a req/gnt/rvalid handshake:
//   - request fields: sel_rd, mem_re/we, mem_size, ALU result as address, rs2 as store data
//  Does byte-lane steering, load alignment and sign/zero extension.
//  Stalls upstream until the access retires, then presents the writeback result.
// PARAMETERS
//  MAX_WAIT  16  cycles in REQ+RESP before the access is aborted with err_o (>=2)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   reset, synchronous, active-high
//  sel_rd_i        in   5   destination register from execute
//  mem_re_i        in   1   load request
//  mem_we_i        in   1   store request (wins if both set)
//  mem_size_i      in   data_size_e   BYTE/HALF/WORD
//  mem_unsigned_i  in   1   load zero-extends when 1
//  addr_i          in   32  ALU result: byte address, or writeback value for non-memory ops
//  wdata_i         in   32  store data (rs2)
//  stall_o         out  1   upstream holds all *_i stable while high
//  dmem_req_o      out  1   memory request, held until dmem_gnt_i
//  dmem_we_o       out  1   1=write
//  dmem_addr_o     out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_be_o       out  4   byte enables
//  dmem_wdata_o    out  32  lane-replicated store data
//  dmem_gnt_i      in   1   request accepted
//  dmem_rvalid_i   in   1   read data valid, earliest one cycle after gnt
//  dmem_rdata_i    in   32  read data word
//  sel_rd_o        out  5   writeback register
//  rd_we_o         out  1   writeback enable, one-cycle pulse per retiring load/ALU op
//  rd_data_o       out  32  writeback data
//  err_o           out  1   one-cycle pulse on timeout abort
//  misalign_o      out  1   one-cycle pulse on trapped misaligned access (0 if macro off)
// BEHAVIOUR
//  Reset (sync, rst=1)
//   - all outputs 0; state IDLE; wait counter 0.
//   - Mid-transaction reset abandons the access: dmem_req_o low after the edge.
//   - A late dmem_rvalid_i is ignored in IDLE.
//  Non-memory op (re=we=0), IDLE
//   - stall_o=0
//   - next edge: sel_rd_o<=sel_rd_i, rd_data_o<=addr_i, rd_we_o<=(sel_rd_i!=0). Latency 1.
//  FSM
//   - IDLE -> REQ on re|we: latch addr, size, unsigned, rd, we, lanes; stall_o=1 this cycle.
//   - REQ: dmem_req_o=1, stall_o=1, fields constant.
//       - gnt & store -> IDLE, stall_o=0 that cycle (retire, rd_we_o<=0).
//       - gnt & load  -> RESP.
//   - RESP: stall_o=!dmem_rvalid_i.
//       - On rvalid -> IDLE; next edge rd_we_o<=(rd!=0), rd_data_o<=extended data.
//   - rvalid in REQ or IDLE is ignored.
//  Timeout
//   - Counter clears on IDLE->REQ and increments each REQ/RESP cycle.
//   - On reaching MAX_WAIT-1 without completion -> IDLE:
//       - stall_o=0 that cycle
//       - err_o pulses next cycle
//       - no writeback; op consumed
//  Whenever stall_o=1: rd_we_o<=0 (bubble); sel_rd_o/rd_data_o hold.
//  Lanes (a=addr[1:0])
//   - BYTE: be=4'b0001<<a, wdata={4{wdata_i[7:0]}}
//   - HALF: be=4'b0011<<{a[1],1'b0}, wdata={2{wdata_i[15:0]}}
//   - WORD: be=4'hF, wdata=wdata_i
//  Load extract
//   - BYTE: rdata>>(8*a), low 8 bits.
//   - HALF: rdata>>(16*a[1]), low 16 bits.
//   - Sign-extend from msb unless mem_unsigned_i.
//  Misaligned = HALF with a[0]=1, or WORD with a!=0.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined
//   - Misaligned op in IDLE: no request, stall_o=0, op consumed.
//   - misalign_o pulses next cycle; no writeback.
//  MEM_MISALIGN_TRAP_EN undefined
//   - Offending low address bits are treated as 0 (access rounded down).
//   - misalign_o tied 0.
// TESTING
//  - ALU op rd=5 addr=0x1234 -> next cycle rd_we_o=1, sel_rd_o=5, rd_data_o=0x1234, no req
//  - SB addr=0x103 wdata=0xAB, gnt after 2 cycles -> be=4'b1000, wdata=0xABABABAB, addr=0x100; stall low in gnt cycle
//  - LB addr=0x101 rdata=0x0000_8000 -> rd_data_o=0xFFFF_FF80; LBU same -> 0x0000_0080
//  - LH addr=0x102 rdata=0xF00D_0000, rvalid 3 cycles after gnt -> stall_o high until rvalid, rd_data_o=0xFFFF_F00D
//  - No gnt for MAX_WAIT cycles -> err_o one pulse, rd_we_o=0, back to IDLE; rst during RESP -> req low, late rvalid ignored
//  - LW addr=0x102 -> with macro: misalign_o pulse, no req; without: req addr=0x100, be=4'hF

Source files
------------

// File: rtl/mem_access.sv
// Memory pipeline stage: byte-lane steering, req/gnt/rvalid data-memory handshake with timeout,
// load alignment and extension. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
package mem_access_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } data_size_e;
endpackage

module mem_access
    import mem_access_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       sel_rd_i,
    input  logic             mem_re_i,
    input  logic             mem_we_i,
    input  data_size_e       mem_size_i,
    input  logic             mem_unsigned_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic             stall_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [31:0]      dmem_addr_o,
    output logic [3:0]       dmem_be_o,
    output logic [31:0]      dmem_wdata_o,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    input  logic [31:0]      dmem_rdata_i,
    output logic [4:0]       sel_rd_o,
    output logic             rd_we_o,
    output logic [31:0]      rd_data_o,
    output logic             err_o,
    output logic             misalign_o
);
    localparam int CW = $clog2(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    data_size_e    size_q, size_d;
    logic          uns_q, uns_d;
    logic          we_q, we_d;
    logic [4:0]    rd_q, rd_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [4:0]    sel_rd_q, sel_rd_d;
    logic          rd_we_q, rd_we_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          err_q, err_d;
    logic          mis_q, mis_d;

    logic          mem_op, trap, timeout;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   ext;

    assign mem_op  = mem_re_i | mem_we_i;
    assign timeout = (cnt_q == CW'(MAX_WAIT - 1));

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (mem_size_i == HALF) ? addr_i[0]
                                             : ((mem_size_i != BYTE) && (addr_i[1:0] != 2'b00));
    assign trap = mem_op & misaligned;
`else
    assign trap = 1'b0;
`endif

    // HALF ignores a[0] and WORD ignores a[1:0], so untrapped misaligned ops round down.
    always_comb begin
        be_new    = 4'hF;
        wdata_new = wdata_i;
        case (mem_size_i)
            BYTE: begin
                be_new    = 4'b0001 << addr_i[1:0];
                wdata_new = {4{wdata_i[7:0]}};
            end
            HALF: begin
                be_new    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_new = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_v = dmem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        half_v = dmem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            BYTE:    ext = {{24{~uns_q & byte_v[7]}}, byte_v};
            HALF:    ext = {{16{~uns_q & half_v[15]}}, half_v};
            default: ext = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        we_d       = we_q;
        rd_d       = rd_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        sel_rd_d   = sel_rd_q;
        rd_data_d  = rd_data_q;
        rd_we_d    = 1'b0;
        err_d      = 1'b0;
        mis_d      = 1'b0;
        stall_o    = 1'b0;
        dmem_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (trap) begin
                    mis_d = 1'b1;
                end else if (mem_op) begin
                    stall_o = 1'b1;
                    state_d = REQ;
                    cnt_d   = '0;
                    addr_d  = addr_i;
                    size_d  = mem_size_i;
                    uns_d   = mem_unsigned_i;
                    we_d    = mem_we_i;
                    rd_d    = sel_rd_i;
                    be_d    = be_new;
                    wdata_d = wdata_new;
                end else begin
                    sel_rd_d  = sel_rd_i;
                    rd_data_d = addr_i;
                    rd_we_d   = (sel_rd_i != 5'd0);
                end
            end
            REQ: begin
                dmem_req_o = 1'b1;
                stall_o    = 1'b1;
                cnt_d      = cnt_q + CW'(1);
                // A store grant retires even in the final wait cycle; a load grant there does not.
                if (dmem_gnt_i && we_q) begin
                    state_d = IDLE;
                    stall_o = 1'b0;
                end else if (timeout) begin
                    state_d = IDLE;
                    stall_o = 1'b0;
                    err_d   = 1'b1;
                end else if (dmem_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                stall_o = ~dmem_rvalid_i;
                cnt_d   = cnt_q + CW'(1);
                if (dmem_rvalid_i) begin
                    state_d   = IDLE;
                    sel_rd_d  = rd_q;
                    rd_data_d = ext;
                    rd_we_d   = (rd_q != 5'd0);
                end else if (timeout) begin
                    state_d = IDLE;
                    stall_o = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            size_q    <= BYTE;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            sel_rd_q  <= '0;
            rd_we_q   <= 1'b0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            sel_rd_q  <= sel_rd_d;
            rd_we_q   <= rd_we_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
            mis_q     <= mis_d;
        end
    end

    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign sel_rd_o     = sel_rd_q;
    assign rd_we_o      = rd_we_q;
    assign rd_data_o    = rd_data_q;
    assign err_o        = err_q;
    assign misalign_o   = mis_q;
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: random ops with a behavioural model, expected responses queued
// at issue time and popped by an independent monitor.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int MW = 16;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, rst;
    logic [4:0]  sel_rd_i;
    logic        mem_re_i, mem_we_i, mem_unsigned_i;
    data_size_e  mem_size_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [4:0]  sel_rd_o;
    logic        rd_we_o, err_o, misalign_o;
    logic [31:0] rd_data_o;

    mem_access #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .sel_rd_i(sel_rd_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .sel_rd_o(sel_rd_o), .rd_we_o(rd_we_o), .rd_data_o(rd_data_o), .err_o(err_o),
        .misalign_o(misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int kind; logic [4:0] sel; logic [31:0] data;} ev_t;  // 0 wb, 1 err, 2 misalign
    typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} rq_t;
    ev_t evq[$];
    rq_t rqq[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int offs(input data_size_e s, input logic [1:0] a);
        if (s == BYTE) return int'(a);
        if (s == HALF) return (a >= 2'd2) ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] load_val(input data_size_e s, input bit uns,
                                             input logic [1:0] a, input logic [31:0] rdata);
        logic [31:0] w, v;
        w = rdata >> (8 * offs(s, a));
        case (s)
            BYTE: begin v = w & 32'hFF;   if (!uns && v > 32'd127)   v = v - 32'd256;   end
            HALF: begin v = w & 32'hFFFF; if (!uns && v > 32'd32767) v = v - 32'd65536; end
            default: v = rdata;
        endcase
        return v;
    endfunction

    task automatic bubble();
        mem_re_i = 1'b0; mem_we_i = 1'b0; sel_rd_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    endtask

    // gd: REQ cycles before gnt; rl: cycles from gnt to rvalid. Starts and ends at posedge+1.
    task automatic run_op(input bit re, input bit we, input data_size_e sz, input bit uns,
                          input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wd,
                          input int gd, input int rl, input logic [31:0] rdata, input string nm);
        bit  mem, mis, acc, done;
        int  c, exp_n, n, t, late;
        int  o;
        rq_t r;
        mem = re | we;
        mis = (sz == HALF && addr[0]) || (sz == WORD && addr[1:0] != 2'b00);
        acc = mem && !(TRAP && mis);
        o   = offs(sz, addr[1:0]);
        late = -100;
        if (!mem) begin
            exp_n = 1;
            if (rd != 0) evq.push_back('{kind: 0, sel: rd, data: addr});
        end else if (!acc) begin
            exp_n = 1;
            evq.push_back('{kind: 2, sel: 5'd0, data: 32'd0});
        end else begin
            c = we ? gd : gd + rl;
            exp_n = 2 + ((c < MW - 1) ? c : MW - 1);
            if (gd <= MW - 1) begin
                r.we    = we;
                r.addr  = addr & 32'hFFFF_FFFC;
                r.be    = (sz == BYTE) ? 4'(1 << o) : (sz == HALF) ? 4'(3 << o) : 4'hF;
                r.wdata = (sz == BYTE) ? (wd & 32'hFF) * 32'h0101_0101 :
                          (sz == HALF) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
                rqq.push_back(r);
                if (!we) late = gd + rl;
            end
            if (c > MW - 1) evq.push_back('{kind: 1, sel: 5'd0, data: 32'd0});
            else if (!we && rd != 0) evq.push_back('{kind: 0, sel: rd, data: load_val(sz, uns, addr[1:0], rdata)});
        end
        mem_re_i = re; mem_we_i = we; mem_size_i = sz; mem_unsigned_i = uns;
        sel_rd_i = rd; addr_i = addr; wdata_i = wd;
        t = -1; n = 0; done = 1'b0;
        while (!done && n < 64) begin
            dmem_gnt_i = acc && (t == gd);
            if (t == late) begin
                dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
            end else if (!acc || we || t <= gd) begin
                // rvalid outside the response window must be ignored
                dmem_rvalid_i = ($urandom_range(0, 3) == 0); dmem_rdata_i = $urandom;
            end else begin
                dmem_rvalid_i = 1'b0;
            end
            @(negedge clk);
            if (!acc) chk({nm, "_noreq"}, dmem_req_o, 1'b0);
            done = !stall_o;
            n++;
            @(posedge clk); #1;
            t++;
        end
        chk({nm, "_cycles"}, n, exp_n);
        bubble();
        while (t <= late) begin
            dmem_rvalid_i = (t == late); dmem_rdata_i = $urandom;
            @(posedge clk); #1;
            t++;
        end
        dmem_rvalid_i = 1'b0;
    endtask

    rq_t mr;
    ev_t me;
    int  mk;
    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_req_o && dmem_gnt_i) begin
                if (rqq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_req: got request addr 0x%08h, expected none", dmem_addr_o);
                end else begin
                    mr = rqq.pop_front();
                    chk("req_we", dmem_we_o, mr.we);
                    chk("req_addr", dmem_addr_o, mr.addr);
                    chk("req_be", dmem_be_o, mr.be);
                    if (mr.we) chk("req_wdata", dmem_wdata_o, mr.wdata);
                end
            end
            if (rd_we_o || err_o || misalign_o) begin
                mk = rd_we_o ? 0 : (err_o ? 1 : 2);
                if (evq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_event: got kind %0d (rd_we=%0b err=%0b mis=%0b), expected none",
                             mk, rd_we_o, err_o, misalign_o);
                end else begin
                    me = evq.pop_front();
                    chk("ev_onehot", $countones({rd_we_o, err_o, misalign_o}), 1);
                    chk("ev_kind", mk, me.kind);
                    if (me.kind == 0) begin
                        chk("wb_sel", sel_rd_o, me.sel);
                        chk("wb_data", rd_data_o, me.data);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, gd, rl;
        data_size_e sz;
        rst = 1'b1; mem_size_i = WORD; mem_unsigned_i = 1'b0; addr_i = '0; wdata_i = '0;
        dmem_rdata_i = '0;
        bubble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall_o, 0);
        chk("rst_req", dmem_req_o, 0);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_be", dmem_be_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        chk("rst_sel", sel_rd_o, 0);
        chk("rst_rdwe", rd_we_o, 0);
        chk("rst_rddata", rd_data_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_mis", misalign_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(0, 0, WORD, 0, 5'd5, 32'h1234, 0, 0, 1, 0, "alu");
        run_op(0, 1, BYTE, 0, 5'd0, 32'h103, 32'hAB, 2, 1, 0, "sb");
        run_op(1, 0, BYTE, 0, 5'd7, 32'h101, 0, 1, 1, 32'h0000_8000, "lb");
        run_op(1, 0, BYTE, 1, 5'd8, 32'h101, 0, 0, 2, 32'h0000_8000, "lbu");
        run_op(1, 0, HALF, 0, 5'd9, 32'h102, 0, 1, 3, 32'hF00D_0000, "lh");
        run_op(0, 1, WORD, 0, 5'd0, 32'h200, 32'hDEAD_BEEF, MW + 4, 1, 0, "sw_timeout");
        run_op(1, 0, WORD, 0, 5'd3, 32'h300, 0, 2, MW + 2, 32'h1, "lw_timeout_late");
        run_op(1, 0, WORD, 0, 5'd4, 32'h102, 0, 1, 1, 32'hCAFE_F00D, "lw_misaligned");
        run_op(1, 1, HALF, 0, 5'd6, 32'h406, 32'h1234_5678, 0, 1, 0, "re_we_store_wins");

        // Reset while waiting for read data: the access is dropped and a late rvalid ignored.
        mem_re_i = 1'b1; mem_size_i = WORD; sel_rd_i = 5'd6; addr_i = 32'h400;
        @(negedge clk); chk("rstseq_stall_idle", stall_o, 1);
        @(posedge clk); #1;
        dmem_gnt_i = 1'b1;
        rqq.push_back('{we: 1'b0, addr: 32'h400, be: 4'hF, wdata: 32'h0});
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        @(negedge clk);
        chk("rstseq_stall_resp", stall_o, 1);
        chk("rstseq_req_resp", dmem_req_o, 0);
        @(posedge clk); #1;
        rst = 1'b1; bubble();
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstseq_req_low", dmem_req_o, 0);
        chk("rstseq_stall_low", stall_o, 0);
        chk("rstseq_rdwe", rd_we_o, 0);
        chk("rstseq_rddata", rd_data_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk); chk("rstseq_late_rvalid", rd_we_o, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            sz   = data_size_e'($urandom_range(0, 2));
            gd   = ($urandom_range(0, 9) == 0) ? $urandom_range(MW - 3, MW + 3) : $urandom_range(0, 4);
            rl   = ($urandom_range(0, 9) == 0) ? $urandom_range(MW - 4, MW + 2) : $urandom_range(1, 4);
            run_op(kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   $urandom, $urandom, gd, rl, $urandom, "rnd");
        end

        bubble();
        repeat (4) @(posedge clk);
        #1;
        chk("evq_drained", evq.size(), 0);
        chk("rqq_drained", rqq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
